// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: control-bundle bit positions and memory access size codes.
package mips_pkg;

   localparam int CTRL_W       = 18;
   localparam int CTRL_LOAD    = 9;
   localparam int CTRL_RF_EN   = 8;
   localparam int CTRL_TA      = 7;
   localparam int CTRL_SIZE_HI = 6;
   localparam int CTRL_SIZE_LO = 5;
   localparam int CTRL_RW      = 4;
   localparam int CTRL_SE      = 3;
   localparam int CTRL_MEM_EN  = 2;

   // The reserved code behaves as a word access.
   typedef enum logic [1:0] {
      SIZE_WORD = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_BYTE = 2'b10,
      SIZE_RSVD = 2'b11
   } mem_size_e;

endpackage

// File: rtl/load_formatter.sv
// Big-endian load data formatter: picks the byte/halfword lane, extends it and
// flags accesses that are not naturally aligned for their size.
module load_formatter
   import mips_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [1:0]        addr,
   input  mem_size_e         size,
   input  logic              se,
   output logic [DATA_W-1:0] data,
   output logic              misalign
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      data     = mem_rdata;
      misalign = 1'b0;
      byte_v   = mem_rdata[31:24];
      half_v   = mem_rdata[31:16];
      case (addr)
         2'b00:   byte_v = mem_rdata[31:24];
         2'b01:   byte_v = mem_rdata[23:16];
         2'b10:   byte_v = mem_rdata[15:8];
         default: byte_v = mem_rdata[7:0];
      endcase
      if (addr[1]) half_v = mem_rdata[15:0];
      case (size)
         SIZE_BYTE: data = {{(DATA_W-8){se & byte_v[7]}}, byte_v};
         SIZE_HALF: begin
            data     = {{(DATA_W-16){se & half_v[15]}}, half_v};
            misalign = addr[0];
         end
         default:   misalign = (addr != 2'b00);
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage register: formats loads, selects the write-back value, and counts
// retired instructions and loads.
module mem_wb_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              valid_in,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] link_addr,
   input  logic [4:0]        dest_in,
   output logic [DATA_W-1:0] wb_data,
   output logic [4:0]        wb_reg,
   output logic              wb_en,
   output logic              misalign_exc,
   output logic [CNT_W-1:0]  retired_cnt,
   output logic [CNT_W-1:0]  load_cnt
);

   logic              load_instr, rf_enable, ta_instr, mem_se, mem_enable;
   mem_size_e         mem_size;
   logic [DATA_W-1:0] fmt_data, sel_data;
   logic              fmt_misalign, misalign;
   logic              unused_ctrl;

   logic [DATA_W-1:0] wb_data_d, wb_data_q;
   logic [4:0]        wb_reg_d, wb_reg_q;
   logic              wb_en_d, wb_en_q;
   logic              misalign_exc_d, misalign_exc_q;
   logic [CNT_W-1:0]  retired_cnt_d, retired_cnt_q;
   logic [CNT_W-1:0]  load_cnt_d, load_cnt_q;

   assign load_instr  = ctrl_in[CTRL_LOAD];
   assign rf_enable   = ctrl_in[CTRL_RF_EN];
   assign ta_instr    = ctrl_in[CTRL_TA];
   assign mem_size    = mem_size_e'(ctrl_in[CTRL_SIZE_HI:CTRL_SIZE_LO]);
   assign mem_se      = ctrl_in[CTRL_SE];
   assign mem_enable  = ctrl_in[CTRL_MEM_EN];
   assign unused_ctrl = ^{ctrl_in[CTRL_W-1:CTRL_LOAD+1], ctrl_in[CTRL_RW], ctrl_in[1:0]};

   load_formatter #(.DATA_W(DATA_W)) u_load_formatter (
      .mem_rdata (mem_rdata),
      .addr      (alu_result[1:0]),
      .size      (mem_size),
      .se        (mem_se),
      .data      (fmt_data),
      .misalign  (fmt_misalign)
   );

   // Loads with mem_enable low are formatted but never raise a misalign.
   assign misalign = load_instr & mem_enable & fmt_misalign;
   assign sel_data = ta_instr ? link_addr : (load_instr ? fmt_data : alu_result);

   always_comb begin
      wb_data_d      = wb_data_q;
      wb_reg_d       = wb_reg_q;
      wb_en_d        = wb_en_q;
      misalign_exc_d = misalign_exc_q;
      retired_cnt_d  = retired_cnt_q;
      load_cnt_d     = load_cnt_q;
      if (flush || (!stall && !valid_in)) begin
         wb_data_d      = '0;
         wb_reg_d       = '0;
         wb_en_d        = 1'b0;
         misalign_exc_d = 1'b0;
      end else if (!stall) begin
         wb_data_d      = misalign ? '0 : sel_data;
         wb_reg_d       = dest_in;
         wb_en_d        = rf_enable & ~misalign & (dest_in != 5'd0);
         misalign_exc_d = misalign;
         if (!misalign) begin
            retired_cnt_d = retired_cnt_q + CNT_W'(1);
            if (load_instr) load_cnt_d = load_cnt_q + CNT_W'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_data_q      <= '0;
         wb_reg_q       <= '0;
         wb_en_q        <= 1'b0;
         misalign_exc_q <= 1'b0;
         retired_cnt_q  <= '0;
         load_cnt_q     <= '0;
      end else begin
         wb_data_q      <= wb_data_d;
         wb_reg_q       <= wb_reg_d;
         wb_en_q        <= wb_en_d;
         misalign_exc_q <= misalign_exc_d;
         retired_cnt_q  <= retired_cnt_d;
         load_cnt_q     <= load_cnt_d;
      end
   end

   assign wb_data      = wb_data_q;
   assign wb_reg       = wb_reg_q;
   assign wb_en        = wb_en_q;
   assign misalign_exc = misalign_exc_q;
   assign retired_cnt  = retired_cnt_q;
   assign load_cnt     = load_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage built with 4-bit counters so counter wrap is reachable.
module tb_mem_wb_stage;
   import mips_pkg::*;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset, stall, flush, valid_in;
   logic [CTRL_W-1:0] ctrl_in;
   logic [DATA_W-1:0] alu_result, mem_rdata, link_addr;
   logic [4:0]        dest_in;
   logic [DATA_W-1:0] wb_data;
   logic [4:0]        wb_reg;
   logic              wb_en, misalign_exc;
   logic [CNT_W-1:0]  retired_cnt, load_cnt;

   int vectors     = 0;
   int miscompares = 0;

   mem_wb_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .valid_in     (valid_in),
      .ctrl_in      (ctrl_in),
      .alu_result   (alu_result),
      .mem_rdata    (mem_rdata),
      .link_addr    (link_addr),
      .dest_in      (dest_in),
      .wb_data      (wb_data),
      .wb_reg       (wb_reg),
      .wb_en        (wb_en),
      .misalign_exc (misalign_exc),
      .retired_cnt  (retired_cnt),
      .load_cnt     (load_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [CTRL_W-1:0] mk_ctrl(input logic load, input logic rf, input logic ta,
                                                 input logic [1:0] size, input logic rw,
                                                 input logic se, input logic men);
      logic [CTRL_W-1:0] c;
      c = '0;
      c[CTRL_LOAD]                 = load;
      c[CTRL_RF_EN]                = rf;
      c[CTRL_TA]                   = ta;
      c[CTRL_SIZE_HI:CTRL_SIZE_LO] = size;
      c[CTRL_RW]                   = rw;
      c[CTRL_SE]                   = se;
      c[CTRL_MEM_EN]               = men;
      return c;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [31:0] data, input logic [4:0] rd,
                            input logic en, input logic mis, input logic [3:0] ret,
                            input logic [3:0] lds);
      check({tag, ".wb_data"}, wb_data, data);
      check({tag, ".wb_reg"}, 32'(wb_reg), 32'(rd));
      check({tag, ".wb_en"}, 32'(wb_en), 32'(en));
      check({tag, ".misalign"}, 32'(misalign_exc), 32'(mis));
      check({tag, ".retired"}, 32'(retired_cnt), 32'(ret));
      check({tag, ".loads"}, 32'(load_cnt), 32'(lds));
   endtask

   task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [31:0] alu,
                        input logic [31:0] link, input logic [4:0] d);
      valid_in   = v;
      ctrl_in    = c;
      alu_result = alu;
      link_addr  = link;
      dest_in    = d;
   endtask

   logic [CTRL_W-1:0] c_lb_s, c_lb_u, c_lh_s, c_lw, c_jal, c_add, c_sw;

   initial begin
      c_lb_s = mk_ctrl(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1);
      c_lb_u = mk_ctrl(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
      c_lh_s = mk_ctrl(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1);
      c_lw   = mk_ctrl(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
      c_jal  = mk_ctrl(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      c_add  = mk_ctrl(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      c_sw   = mk_ctrl(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);

      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      mem_rdata = 32'h8A4B_C0D1;
      drive(1'b1, c_add, 32'h0000_0123, 32'h0, 5'd4);
      step();
      step();
      check_out("reset", 32'h0, 5'd0, 1'b0, 1'b0, 4'd0, 4'd0);
      reset = 1'b0;

      drive(1'b1, c_lb_s, 32'h0000_1001, 32'h0, 5'd5); step();
      check_out("lb_01_se", 32'h0000_004B, 5'd5, 1'b1, 1'b0, 4'd1, 4'd1);
      drive(1'b1, c_lb_s, 32'h0000_1000, 32'h0, 5'd5); step();
      check_out("lb_00_se", 32'hFFFF_FF8A, 5'd5, 1'b1, 1'b0, 4'd2, 4'd2);
      drive(1'b1, c_lb_u, 32'h0000_1000, 32'h0, 5'd5); step();
      check_out("lbu_00", 32'h0000_008A, 5'd5, 1'b1, 1'b0, 4'd3, 4'd3);
      drive(1'b1, c_lb_u, 32'h0000_1003, 32'h0, 5'd6); step();
      check_out("lbu_11", 32'h0000_00D1, 5'd6, 1'b1, 1'b0, 4'd4, 4'd4);
      drive(1'b1, c_lh_s, 32'h0000_1002, 32'h0, 5'd5); step();
      check_out("lh_10_se", 32'hFFFF_C0D1, 5'd5, 1'b1, 1'b0, 4'd5, 4'd5);
      drive(1'b1, c_lh_s, 32'h0000_1003, 32'h0, 5'd5); step();
      check_out("lh_11_mis", 32'h0, 5'd5, 1'b0, 1'b1, 4'd5, 4'd5);

      drive(1'b1, c_jal, 32'h0000_DEAD, 32'h0040_0010, 5'd31); step();
      check_out("jal_r31", 32'h0040_0010, 5'd31, 1'b1, 1'b0, 4'd6, 4'd5);
      drive(1'b1, c_jal, 32'h0000_DEAD, 32'h0040_0010, 5'd0); step();
      check_out("jal_r0", 32'h0040_0010, 5'd0, 1'b0, 1'b0, 4'd7, 4'd5);

      drive(1'b1, c_add, 32'd7, 32'h0, 5'd3); step();
      check_out("add", 32'd7, 5'd3, 1'b1, 1'b0, 4'd8, 4'd5);
      stall = 1'b1;
      drive(1'b1, c_lb_s, 32'd99, 32'h0, 5'd9);
      for (int i = 0; i < 3; i++) begin
         step();
         check_out($sformatf("stall%0d", i), 32'd7, 5'd3, 1'b1, 1'b0, 4'd8, 4'd5);
      end
      flush = 1'b1;
      drive(1'b1, c_add, 32'd11, 32'h0, 5'd3); step();
      check_out("flush_stall", 32'h0, 5'd0, 1'b0, 1'b0, 4'd8, 4'd5);
      stall = 1'b0; flush = 1'b0;

      drive(1'b1, c_sw, 32'h0000_2000, 32'h0, 5'd7); step();
      check_out("store", 32'h0000_2000, 5'd7, 1'b0, 1'b0, 4'd9, 4'd5);
      drive(1'b0, c_add, 32'd12, 32'h0, 5'd8); step();
      check_out("bubble", 32'h0, 5'd0, 1'b0, 1'b0, 4'd9, 4'd5);
      drive(1'b1, c_lw, 32'h0000_1002, 32'h0, 5'd8); step();
      check_out("lw_10_mis", 32'h0, 5'd8, 1'b0, 1'b1, 4'd9, 4'd5);
      drive(1'b1, c_lw, 32'h0000_1004, 32'h0, 5'd8); step();
      check_out("lw_00", 32'h8A4B_C0D1, 5'd8, 1'b1, 1'b0, 4'd10, 4'd6);

      for (int i = 0; i < 5; i++) begin
         drive(1'b1, c_add, 32'(i), 32'h0, 5'd1); step();
      end
      check_out("cnt_15", 32'd4, 5'd1, 1'b1, 1'b0, 4'd15, 4'd6);
      drive(1'b1, c_add, 32'd42, 32'h0, 5'd2); step();
      check_out("cnt_wrap", 32'd42, 5'd2, 1'b1, 1'b0, 4'd0, 4'd6);

      stall = 1'b1; reset = 1'b1; step();
      check_out("reset_in_stall", 32'h0, 5'd0, 1'b0, 1'b0, 4'd0, 4'd0);
      reset = 1'b0; stall = 1'b0;
      drive(1'b1, c_add, 32'd5, 32'h0, 5'd2); step();
      check_out("first_after_reset", 32'd5, 5'd2, 1'b1, 1'b0, 4'd1, 4'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
